// File: rtl/fll_seq_pkg.sv
// Shared types and constants for the FLL frequency sequencer: FSM states,
// the FLL bus request bundle and the CFG1 field layout.
package fll_seq_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD_REQ,
    S_RD_REL,
    S_WR_REQ,
    S_WR_REL,
    S_SETTLE,
    S_WAIT_LOCK
  } state_e;

  typedef struct packed {
    logic        req;
    logic        wrn;
    logic [1:0]  addr;
    logic [31:0] wdata;
  } fll_bus_t;

  localparam logic [1:0] FLL_ADDR_CFG1 = 2'd1;
  localparam int MULT_LSB = 0;
  localparam int MULT_W   = 16;
  localparam int DIV_LSB  = 26;
  localparam int DIV_W    = 4;

  localparam fll_bus_t BUS_IDLE = '{req: 1'b0, wrn: 1'b1, addr: 2'd0, wdata: 32'd0};

  // Only the mult and div fields change; every other CFG1 bit is kept.
  function automatic logic [31:0] cfg1_merge(input logic [31:0] cur,
                                             input logic [MULT_W-1:0] mult,
                                             input logic [DIV_W-1:0] div);
    logic [31:0] r;
    r = cur;
    r[MULT_LSB +: MULT_W] = mult;
    r[DIV_LSB +: DIV_W]   = div;
    return r;
  endfunction

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/fll_seq_sync.sv
// Two-flop synchronizer for the asynchronous FLL ack and lock inputs.
module fll_seq_sync (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o
);

  logic [1:0] ff_q, ff_d;

  always_comb ff_d = {ff_q[0], d_i};

  always_ff @(posedge clk_i) begin
    if (rst_i) ff_q <= '0;
    else       ff_q <= ff_d;
  end

  assign q_o = ff_q[1];

endmodule

// File: rtl/fll_freq_sequencer.sv
// Read-modify-write of FLL CFG1 over the 4-phase FLL bus, then a lock-blanking
// settle window and a wait for stable lock bounded by a timeout.
module fll_freq_sequencer
  import fll_seq_pkg::*;
#(
  parameter int SETTLE_CYCLES = 16,
  parameter int LOCK_STABLE   = 8,
  parameter int LOCK_TIMEOUT  = 4096
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        cmd_valid_i,
  output logic        cmd_ready_o,
  input  logic [15:0] cmd_mult_i,
  input  logic [3:0]  cmd_div_i,
  output logic        busy_o,
  output logic        done_o,
  output logic        err_o,
  output logic        fll_req_o,
  input  logic        fll_ack_i,
  output logic        fll_wrn_o,
  output logic [1:0]  fll_addr_o,
  output logic [31:0] fll_wdata_o,
  input  logic [31:0] fll_rdata_i,
  input  logic        fll_lock_i
);

  localparam int CW = $clog2(max3(SETTLE_CYCLES, LOCK_STABLE, LOCK_TIMEOUT)) + 1;

  logic ack_sync, lock_sync;

  fll_seq_sync u_ack_sync  (.clk_i(clk_i), .rst_i(rst_i), .d_i(fll_ack_i),  .q_o(ack_sync));
  fll_seq_sync u_lock_sync (.clk_i(clk_i), .rst_i(rst_i), .d_i(fll_lock_i), .q_o(lock_sync));

  state_e          state_q, state_d;
  fll_bus_t        bus_q, bus_d;
  logic [15:0]     mult_q, mult_d;
  logic [3:0]      div_q, div_d;
  logic [31:0]     cfg_q, cfg_d;
  logic [CW-1:0]   cnt_q, cnt_d, stab_q, stab_d;
  logic [CW-1:0]   cnt_inc, stab_inc;
  logic [1:0]      prime_q, prime_d;
  logic            done_q, done_d, err_q, err_d;
  logic            accept;

  // Ready waits for the ack synchronizer to refill after reset and for any
  // handshake cut short by reset to finish on the FLL side.
  assign cmd_ready_o = (state_q == S_IDLE) && !ack_sync && (prime_q == 2'd2);
  assign accept      = cmd_valid_i && cmd_ready_o;

  always_comb begin
    state_d  = state_q;
    bus_d    = bus_q;
    mult_d   = mult_q;
    div_d    = div_q;
    cfg_d    = cfg_q;
    cnt_d    = cnt_q;
    stab_d   = stab_q;
    done_d   = 1'b0;
    err_d    = 1'b0;
    prime_d  = (prime_q == 2'd2) ? prime_q : prime_q + 2'd1;
    cnt_inc  = cnt_q + 1'b1;
    stab_inc = lock_sync ? stab_q + 1'b1 : '0;
    case (state_q)
      S_IDLE: if (accept) begin
        if (cmd_mult_i == '0) err_d = 1'b1;
        else begin
          mult_d  = cmd_mult_i;
          div_d   = cmd_div_i;
          state_d = S_RD_REQ;
          bus_d   = '{req: 1'b1, wrn: 1'b1, addr: FLL_ADDR_CFG1, wdata: 32'd0};
        end
      end
      S_RD_REQ: if (ack_sync) begin
        cfg_d     = cfg1_merge(fll_rdata_i, mult_q, div_q);
        bus_d.req = 1'b0;
        state_d   = S_RD_REL;
      end
      S_RD_REL: if (!ack_sync) begin
        bus_d   = '{req: 1'b1, wrn: 1'b0, addr: FLL_ADDR_CFG1, wdata: cfg_q};
        state_d = S_WR_REQ;
      end
      S_WR_REQ: if (ack_sync) begin
        bus_d.req = 1'b0;
        state_d   = S_WR_REL;
      end
      S_WR_REL: if (!ack_sync) begin
        bus_d   = BUS_IDLE;
        cnt_d   = '0;
        state_d = S_SETTLE;
      end
      S_SETTLE: begin
        if (cnt_inc == CW'(SETTLE_CYCLES)) begin
          cnt_d   = '0;
          stab_d  = '0;
          state_d = S_WAIT_LOCK;
        end else cnt_d = cnt_inc;
      end
      S_WAIT_LOCK: begin
        cnt_d  = cnt_inc;
        stab_d = stab_inc;
        if (stab_inc == CW'(LOCK_STABLE)) begin
          done_d  = 1'b1;
          state_d = S_IDLE;
        end else if (cnt_inc == CW'(LOCK_TIMEOUT)) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: begin
        bus_d   = BUS_IDLE;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      bus_q   <= BUS_IDLE;
      mult_q  <= '0;
      div_q   <= '0;
      cfg_q   <= '0;
      cnt_q   <= '0;
      stab_q  <= '0;
      prime_q <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      bus_q   <= bus_d;
      mult_q  <= mult_d;
      div_q   <= div_d;
      cfg_q   <= cfg_d;
      cnt_q   <= cnt_d;
      stab_q  <= stab_d;
      prime_q <= prime_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign busy_o      = (state_q != S_IDLE);
  assign done_o      = done_q;
  assign err_o       = err_q;
  assign fll_req_o   = bus_q.req;
  assign fll_wrn_o   = bus_q.wrn;
  assign fll_addr_o  = bus_q.addr;
  assign fll_wdata_o = bus_q.wdata;

endmodule
